// File: rtl/tdm_demultiplexer.sv
// 4-slot TDM receiver: locks on the frame marker, steers beats to staging, publishes
// frames on out0..out3. Latency: slot-3 beat to outputs/frame_valid is 1 clock.
// No backpressure: valid=0 cycles stall the slot counter. Optional TDM_DEMUX_FRAME_CNT_EN adds frame_count.
module tdm_demultiplexer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic             address0,
    output logic             address1,
    output logic             locked,
    output logic             sync_err
`ifdef TDM_DEMUX_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_count
`endif
);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state;
    logic [1:0]       slot;
    logic [WIDTH-1:0] stage0;
    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;

    assign address0 = slot[1];
    assign address1 = slot[0];
    assign locked   = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            slot        <= 2'd0;
            stage0      <= '0;
            stage1      <= '0;
            stage2      <= '0;
            out0        <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
            frame_count <= 8'd0;
`endif
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (valid) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            stage0 <= in;
                            stage1 <= '0;
                            stage2 <= '0;
                            slot   <= 2'd1;
                            state  <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (slot == 2'd0) begin
                            if (sync) begin
                                stage0 <= in;
                                slot   <= 2'd1;
                            end else begin
                                // Marker missing where slot 0 was due: lost framing.
                                sync_err <= 1'b1;
                                stage0   <= '0;
                                stage1   <= '0;
                                stage2   <= '0;
                                state    <= HUNT;
                            end
                        end else if (sync) begin
                            // Early marker: restart the frame on this beat.
                            sync_err <= 1'b1;
                            stage0   <= in;
                            stage1   <= '0;
                            stage2   <= '0;
                            slot     <= 2'd1;
                        end else begin
                            case (slot)
                                2'd1: begin
                                    stage1 <= in;
                                    slot   <= 2'd2;
                                end
                                2'd2: begin
                                    stage2 <= in;
                                    slot   <= 2'd3;
                                end
                                default: begin
                                    out0        <= stage0;
                                    out1        <= stage1;
                                    out2        <= stage2;
                                    out3        <= in;
                                    frame_valid <= 1'b1;
                                    slot        <= 2'd0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
                                    frame_count <= frame_count + 8'd1;
`endif
                                end
                            endcase
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Randomized and directed bench for tdm_demultiplexer (WIDTH=4) against a frame-level model.
module tb_tdm_demultiplexer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] din = 4'h0;
    logic       valid = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] out0, out1, out2, out3;
    logic       frame_valid, address0, address1, locked, sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [7:0] frame_count;
`endif

    int errors = 0;
    int checks = 0;

    tdm_demultiplexer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .in(din), .valid(valid), .sync(sync),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .frame_valid(frame_valid), .address0(address0), .address1(address1),
        .locked(locked), .sync_err(sync_err)
`ifdef TDM_DEMUX_FRAME_CNT_EN
        , .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    // Frame-level model: the partial frame is just a list of beats collected so far.
    bit         m_locked;
    logic [3:0] m_part[$];
    logic [3:0] m_out[4];
    bit         m_fv, m_se;
    logic [7:0] m_fc;

    function automatic logic [28:0] obs_vec();
        logic [7:0] fc;
`ifdef TDM_DEMUX_FRAME_CNT_EN
        fc = frame_count;
`else
        fc = 8'h00;
`endif
        return {out0, out1, out2, out3, frame_valid, sync_err, locked, address0, address1, fc};
    endfunction

    function automatic logic [28:0] exp_vec();
        logic [1:0] a;
        logic [7:0] fc;
        a = m_locked ? 2'(m_part.size()) : 2'd0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
        fc = m_fc;
`else
        fc = 8'h00;
`endif
        return {m_out[0], m_out[1], m_out[2], m_out[3], m_fv, m_se, m_locked, a, fc};
    endfunction

    task automatic model_apply(input bit r, input bit v, input bit s, input logic [3:0] d);
        m_fv = 0;
        m_se = 0;
        if (r) begin
            m_locked = 0;
            m_part.delete();
            for (int i = 0; i < 4; i++) m_out[i] = 4'h0;
            m_fc = 8'h00;
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1;
                    m_part = {d};
                end
            end else if (m_part.size() == 0) begin
                if (s) m_part = {d};
                else begin
                    m_se = 1;
                    m_locked = 0;
                end
            end else if (s) begin
                m_se = 1;
                m_part = {d};
            end else begin
                m_part.push_back(d);
                if (m_part.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_out[i] = m_part[i];
                    m_fv = 1;
                    m_fc = m_fc + 8'd1;
                    m_part.delete();
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s, input logic [3:0] d);
        reset = r;
        valid = v;
        sync  = s;
        din   = d;
        @(posedge clk);
        model_apply(r, v, s, d);
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 4'($urandom));
        step(1, 1, 0, 4'($urandom));
        checks++;
        if (obs_vec() !== 29'h0) begin
            errors++;
            $display("FAIL reset: got %h required %h", obs_vec(), 29'h0);
        end
    endtask

    task automatic test_frame();
        logic [3:0] beats[4];
        beats = '{4'hA, 4'h3, 4'hC, 4'h5};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, i == 0, beats[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL frame beat%0d: got %h required %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({out0, out1, out2, out3, frame_valid, locked} !== {16'hA3C5, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL frame publish: got %h required %h", {out0, out1, out2, out3, frame_valid, locked}, {16'hA3C5, 2'b11});
        end
        step(0, 0, 0, 4'h0);
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame strobe width: got %b required 0", frame_valid);
        end
    endtask

    task automatic test_gapped();
        logic [3:0] beats[4];
        beats = '{4'hA, 4'h3, 4'hC, 4'h5};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, i == 0, beats[i]);
            for (int g = 0; g < 2; g++) begin
                if (i == 3 && g == 0) begin
                    checks++;
                    if ({out0, out1, out2, out3, frame_valid} !== {16'hA3C5, 1'b1}) begin
                        errors++;
                        $display("FAIL gapped publish: got %h required %h", {out0, out1, out2, out3, frame_valid}, {16'hA3C5, 1'b1});
                    end
                end
                step(0, 0, $urandom_range(0, 1), 4'($urandom));
                checks++;
                if ({address0, address1} !== 2'((i + 1) % 4) || frame_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gapped hold: got addr %b fv %b required addr %b fv 0", {address0, address1}, frame_valid, 2'((i + 1) % 4));
                end
            end
        end
    endtask

    task automatic test_early_sync();
        logic [3:0] beats[6];
        bit         syn[6];
        beats = '{4'h1, 4'h2, 4'h7, 4'h8, 4'h9, 4'hF};
        syn   = '{1, 0, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            step(0, 1, syn[i], beats[i]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL early_sync beat%0d: got %h required %h", i, obs_vec(), exp_vec());
            end
            if (i == 2) begin
                checks++;
                if ({sync_err, frame_valid, locked} !== 3'b101) begin
                    errors++;
                    $display("FAIL early_sync err: got %b required 101", {sync_err, frame_valid, locked});
                end
            end
        end
        checks++;
        if ({out0, out1, out2, out3} !== 16'h789F) begin
            errors++;
            $display("FAIL early_sync publish: got %h required 789f", {out0, out1, out2, out3});
        end
    endtask

    task automatic test_missing_sync();
        for (int i = 0; i < 4; i++) step(0, 1, i == 0, 4'(i + 1));
        step(0, 1, 0, 4'h6);
        checks++;
        if ({sync_err, locked, out0, out1, out2, out3} !== {2'b10, 16'h1234}) begin
            errors++;
            $display("FAIL missing_sync: got %h required %h", {sync_err, locked, out0, out1, out2, out3}, {2'b10, 16'h1234});
        end
        step(0, 1, 0, 4'h9);
        step(0, 1, 1, 4'hB);
        checks++;
        if (obs_vec() !== exp_vec() || locked !== 1'b1) begin
            errors++;
            $display("FAIL missing_sync relock: got %h required %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_frame();
        bit fv_seen = 0;
        step(0, 1, 1, 4'hD);
        step(0, 1, 0, 4'hE);
        step(1, 1, 0, 4'h4);
        checks++;
        if (obs_vec() !== 29'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h required 0", obs_vec());
        end
        step(0, 1, 0, 4'h4);
        step(0, 1, 0, 4'h5);
        fv_seen = fv_seen | frame_valid;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, i == 0, 4'(4'hB + i));
            if (i < 3) fv_seen = fv_seen | frame_valid;
        end
        checks++;
        if (fv_seen !== 1'b0 || {out0, out1, out2, out3, frame_valid} !== {16'hBCDE, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid frame: got early %b out %h required 0 and bcde1", fv_seen, {out0, out1, out2, out3, frame_valid});
        end
    endtask

    task automatic test_back_to_back();
        int fv_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            step(0, 1, (i % 4) == 0, 4'($urandom));
            fv_cnt += frame_valid;
            checks++;
            if (obs_vec() !== exp_vec() || frame_valid !== ((i % 4) == 3)) begin
                errors++;
                $display("FAIL back_to_back cyc%0d: got %h required %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (fv_cnt != 20) begin
            errors++;
            $display("FAIL back_to_back count: got %0d required 20", fv_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0, 4'($urandom));
            checks++;
            if (obs_vec() !== exp_vec() || (frame_valid && sync_err)) begin
                errors++;
                $display("FAIL random cyc%0d: got %h required %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef TDM_DEMUX_FRAME_CNT_EN
    task automatic test_frame_count();
        logic [7:0] before;
        step(1, 0, 0, 4'h0);
        for (int f = 0; f < 257; f++) begin
            for (int b = 0; b < 4; b++) step(0, 1, b == 0, 4'($urandom));
            checks++;
            if (frame_count !== 8'((f + 1) % 256) || frame_count !== m_fc) begin
                errors++;
                $display("FAIL frame_count f%0d: got %0d required %0d", f, frame_count, (f + 1) % 256);
            end
        end
        before = frame_count;
        step(0, 1, 0, 4'h3);
        step(0, 1, 1, 4'h3);
        step(0, 1, 1, 4'h3);
        checks++;
        if (frame_count !== before || frame_count !== 8'd1) begin
            errors++;
            $display("FAIL frame_count sync_err: got %0d required 1", frame_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_gapped();
        test_early_sync();
        test_missing_sync();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
`ifdef TDM_DEMUX_FRAME_CNT_EN
        test_frame_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
